// File: rtl/urv_clint_slave.sv
// CLINT responder on the core's dmem OCP port: holds msip, mtime and mtimecmp,
// and drives soft_irq, time_irq and time_val back into the core.
package urv_clint_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } mem_resp_t;
endpackage

module urv_clint_slave
  import urv_clint_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned TICK_DIV  = 1,
  parameter int unsigned TIME_W    = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              time_stop,
  input  logic              req_valid,
  output logic              req_ready,
  input  mem_req_t          req,
  output logic              resp_valid,
  input  logic              resp_ready,
  output mem_resp_t         resp,
  output logic              soft_irq,
  output logic              time_irq,
  output logic [TIME_W-1:0] time_val
);
  localparam int unsigned   PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  localparam logic [15:0] OFF_MSIP    = 16'h0000;
  localparam logic [15:0] OFF_CMP_LO  = 16'h4000;
  localparam logic [15:0] OFF_CMP_HI  = 16'h4004;
  localparam logic [15:0] OFF_TIME_LO = 16'hBFF8;
  localparam logic [15:0] OFF_TIME_HI = 16'hBFFC;

  typedef enum logic {IDLE, RESP} state_t;

  state_t            state_q, state_d;
  logic              accept, wr;
  logic [15:0]       off, off_word;
  logic              sel_msip, sel_cmp_lo, sel_cmp_hi, sel_time_lo, sel_time_hi;
  logic [31:0]       rdata_acc, rdata_q, rdata_d;
  logic              msip_q, msip_d;
  logic [TIME_W-1:0] mtime_q, mtime_d, mtime_inc;
  logic [TIME_W-1:0] mtimecmp_q, mtimecmp_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic              tick, time_irq_q;
  logic              unused_addr;

  function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] wdata,
                                           input logic [3:0] be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? wdata[8*b +: 8] : old[8*b +: 8];
    end
    return res;
  endfunction

  // Only the low 16 offset bits decode; the upper address bits belong to the OCP decoder.
  assign off         = req.addr[15:0] - BASE_ADDR[15:0];
  assign off_word    = {off[15:2], 2'b00};
  assign unused_addr = ^{req.addr[31:16], off[1:0]};

  assign sel_msip    = (off_word == OFF_MSIP);
  assign sel_cmp_lo  = (off_word == OFF_CMP_LO);
  assign sel_cmp_hi  = (off_word == OFF_CMP_HI);
  assign sel_time_lo = (off_word == OFF_TIME_LO);
  assign sel_time_hi = (off_word == OFF_TIME_HI);

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid)  state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
  end

  assign accept = req_valid & req_ready;
  assign wr     = accept & req.we;

  always_comb begin
    rdata_acc = '0;
    if (sel_msip)         rdata_acc = {31'b0, msip_q};
    else if (sel_cmp_lo)  rdata_acc = mtimecmp_q[31:0];
    else if (sel_cmp_hi)  rdata_acc = mtimecmp_q[TIME_W-1:32];
    else if (sel_time_lo) rdata_acc = mtime_q[31:0];
    else if (sel_time_hi) rdata_acc = mtime_q[TIME_W-1:32];
  end

  // A bus write to one mtime half overrides the tick for that half only, so the
  // untouched half (and any unmasked bytes) still see the incremented count.
  always_comb begin
    tick      = ~time_stop & (presc_q == PRESC_MAX);
    presc_d   = presc_q;
    if (!time_stop) presc_d = tick ? '0 : presc_q + PW'(1);
    mtime_inc = tick ? mtime_q + TIME_W'(1) : mtime_q;

    mtime_d = mtime_inc;
    if (wr && sel_time_lo) mtime_d[31:0] = merge_be(mtime_inc[31:0], req.wdata, req.be);
    if (wr && sel_time_hi)
      mtime_d[TIME_W-1:32] = merge_be(mtime_inc[TIME_W-1:32], req.wdata, req.be);

    mtimecmp_d = mtimecmp_q;
    if (wr && sel_cmp_lo) mtimecmp_d[31:0] = merge_be(mtimecmp_q[31:0], req.wdata, req.be);
    if (wr && sel_cmp_hi)
      mtimecmp_d[TIME_W-1:32] = merge_be(mtimecmp_q[TIME_W-1:32], req.wdata, req.be);

    msip_d = msip_q;
    if (wr && sel_msip && req.be[0]) msip_d = req.wdata[0];

    rdata_d = accept ? rdata_acc : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rdata_q    <= '0;
      msip_q     <= 1'b0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      presc_q    <= '0;
      time_irq_q <= 1'b0;
    end else begin
      rdata_q    <= rdata_d;
      msip_q     <= msip_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      presc_q    <= presc_d;
      time_irq_q <= (mtime_q >= mtimecmp_q);
    end
  end

  assign resp     = '{rdata: rdata_q, err: 1'b0};
  assign soft_irq = msip_q;
  assign time_irq = time_irq_q;
  assign time_val = mtime_q;

endmodule
